ps2_keycode_rx: RTL and testbench

PS2_KEYCODE_RX -- requirements
Module: ps2_keycode_rx

---
 rtl/ps2_keycode_rx.sv | 154 +++++++++++++++
 tb/tb_ps2_keycode_rx.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_keycode_rx.sv
// ps2_keycode_rx
//   Receives PS/2 keyboard frames (start, 8 data bits LSB first, odd parity,
//   stop) and keeps the last two good bytes as a 16-bit keycode
//   {previous, latest}. Scan codes are not interpreted.
//
//   Handshake: keycode_valid, parity_err and frame_err are single-cycle,
//   mutually exclusive strobes with no ready/backpressure. keycode is stable
//   from the keycode_valid cycle until the next keycode_valid.
//
// Ports
//   clk           system clock (single clock domain)
//   rst_n         asynchronous active-low reset
//   ps2_clk       raw PS/2 clock line (asynchronous)
//   ps2_data      raw PS/2 data line (asynchronous)
//   keycode       {previous byte, latest byte}
//   keycode_valid one-cycle pulse on a keycode update
//   parity_err    one-cycle pulse on an odd-parity failure
//   frame_err     one-cycle pulse on a bad stop bit or an inter-edge timeout
//   busy          high while the receiver is inside a frame
//   dbg_state     current FSM state (0 IDLE, 1 DATA, 2 PARITY, 3 STOP)
module ps2_keycode_rx #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] keycode,
    output logic        keycode_valid,
    output logic        parity_err,
    output logic        frame_err,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int TCW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t          state;
    logic            clk_s1, clk_s2, data_s1, data_s2;
    logic            filt_clk, filt_clk_d;
    logic [FCW-1:0]  filt_cnt;
    logic [TCW-1:0]  tmo_cnt;
    logic [2:0]      bit_cnt;
    logic [7:0]      shreg;
    logic            par_bit;
    logic            fall;

    // Synchronizers and glitch filter. Everything resets to the PS/2 idle
    // level (high) so releasing reset never manufactures a falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1     <= 1'b1;
            clk_s2     <= 1'b1;
            data_s1    <= 1'b1;
            data_s2    <= 1'b1;
            filt_clk   <= 1'b1;
            filt_clk_d <= 1'b1;
            filt_cnt   <= '0;
        end else begin
            clk_s1     <= ps2_clk;
            clk_s2     <= clk_s1;
            data_s1    <= ps2_data;
            data_s2    <= data_s1;
            filt_clk_d <= filt_clk;
            // Flip only on the FILTER_LEN-th consecutive differing sample;
            // any agreeing sample restarts the run.
            if (clk_s2 != filt_clk) begin
                if (filt_cnt == FCW'(FILTER_LEN - 1)) begin
                    filt_clk <= clk_s2;
                    filt_cnt <= '0;
                end else begin
                    filt_cnt <= filt_cnt + 1'b1;
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    assign fall      = filt_clk_d & ~filt_clk;
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    // Frame FSM. Outputs are registered, so a pulse appears the cycle after
    // the stop-bit edge, in the same cycle the FSM is back in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            keycode       <= '0;
            keycode_valid <= 1'b0;
            parity_err    <= 1'b0;
            frame_err     <= 1'b0;
            tmo_cnt       <= '0;
            bit_cnt       <= '0;
            shreg         <= '0;
            par_bit       <= 1'b0;
        end else begin
            keycode_valid <= 1'b0;
            parity_err    <= 1'b0;
            frame_err     <= 1'b0;
            if (state == IDLE) begin
                tmo_cnt <= '0;
                if (fall && !data_s2) begin
                    state   <= DATA;
                    bit_cnt <= '0;
                    shreg   <= '0;
                end
            end else if (fall) begin
                tmo_cnt <= '0;
                case (state)
                    DATA: begin
                        shreg   <= {data_s2, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) state <= PARITY;
                    end
                    PARITY: begin
                        par_bit <= data_s2;
                        state   <= STOP;
                    end
                    default: begin
                        state <= IDLE;
                        if (!data_s2) begin
                            frame_err <= 1'b1;
                        end else if (^{shreg, par_bit}) begin
                            keycode       <= {keycode[7:0], shreg};
                            keycode_valid <= 1'b1;
                        end else begin
                            parity_err <= 1'b1;
                        end
                    end
                endcase
            end else if (tmo_cnt == TCW'(TIMEOUT_CYC - 2)) begin
                // Counter restarts at 0 the cycle after an edge, so this fires
                // with the pulse landing TIMEOUT_CYC cycles after that edge.
                frame_err <= 1'b1;
                state     <= IDLE;
                tmo_cnt   <= '0;
                shreg     <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Bench for ps2_keycode_rx: PS/2 frames driven from tasks, expected pulses
// queued in a scoreboard and consumed by a monitor on the falling clk edge.
module tb_ps2_keycode_rx;

    localparam int FILTER_LEN  = 4;
    localparam int TIMEOUT_CYC = 200;
    localparam logic [1:0] K_VALID = 2'd0, K_PAR = 2'd1, K_FRAME = 2'd2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [15:0] keycode;
    logic        keycode_valid, parity_err, frame_err, busy;
    logic [1:0]  dbg_state;

    int          vectors = 0;
    int          miscompares = 0;
    logic [17:0] exp_q[$];
    logic [15:0] kc_model = 16'h0000;

    ps2_keycode_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .keycode(keycode), .keycode_valid(keycode_valid),
        .parity_err(parity_err), .frame_err(frame_err), .busy(busy),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, queue=%0d", exp_q.size());
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [17:0] got, exp;
        if (!rst_n) begin
            if (keycode_valid || parity_err || frame_err) begin
                vectors++;
                miscompares++;
                $display("FAIL pulse_in_reset: got v=%b p=%b f=%b, want 0", keycode_valid, parity_err, frame_err);
            end
        end else if (keycode_valid || parity_err || frame_err) begin
            vectors++;
            got = {(frame_err ? K_FRAME : (parity_err ? K_PAR : K_VALID)), keycode};
            if (int'(keycode_valid) + int'(parity_err) + int'(frame_err) != 1) begin
                miscompares++;
                $display("FAIL pulse_exclusive: got v=%b p=%b f=%b", keycode_valid, parity_err, frame_err);
            end else if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_pulse: got kind=%0d keycode=%h, want none", got[17:16], got[15:0]);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    miscompares++;
                    $display("FAIL scoreboard: got kind=%0d keycode=%h, want kind=%0d keycode=%h",
                             got[17:16], got[15:0], exp[17:16], exp[15:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One PS/2 bit: data set while clock high, 10-cycle low, 10-cycle high.
    // glitch=1 inserts a FILTER_LEN-2 cycle low pulse before the real edge.
    task automatic ps2_bit(input logic b, input bit glitch);
        @(negedge clk);
        ps2_data = b;
        if (glitch) begin
            wait_cyc(1);
            ps2_clk = 1'b0;
            wait_cyc(FILTER_LEN - 2);
            ps2_clk = 1'b1;
            wait_cyc(6);
        end else begin
            wait_cyc(5);
        end
        ps2_clk = 1'b0;
        wait_cyc(10);
        ps2_clk = 1'b1;
        wait_cyc(5);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par, input logic stop, input int glitch_idx);
        logic [10:0] bits;
        bits = {stop, par, b, 1'b0};
        for (int i = 0; i < 11; i++) ps2_bit(bits[i], i == glitch_idx);
        ps2_data = 1'b1;
        wait_cyc(10);
    endtask

    // Pushes the expected outcome from the model, then sends the frame.
    task automatic frame_expect(input logic [7:0] b, input logic par, input logic stop, input int glitch_idx);
        if (!stop) begin
            exp_q.push_back({K_FRAME, kc_model});
        end else if ((^b) ^ par) begin
            kc_model = {kc_model[7:0], b};
            exp_q.push_back({K_VALID, kc_model});
        end else begin
            exp_q.push_back({K_PAR, kc_model});
        end
        send_frame(b, par, stop, glitch_idx);
    endtask

    task automatic check_idle(input string name, input logic [15:0] want_kc);
        wait_cyc(20);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_drained: got %0d pending pulses, want 0", name, exp_q.size());
            exp_q.delete();
        end
        vectors++;
        if (keycode !== want_kc || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_state: got keycode=%h busy=%b, want keycode=%h busy=0", name, keycode, busy, want_kc);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        kc_model = 16'h0000;
        exp_q.delete();
        wait_cyc(5);
        rst_n = 1'b1;
        wait_cyc(5);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        wait_cyc(4);
        vectors++;
        if (keycode !== 16'h0000 || keycode_valid !== 1'b0 || parity_err !== 1'b0 ||
            frame_err !== 1'b0 || busy !== 1'b0 || dbg_state !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_values: got kc=%h v=%b p=%b f=%b busy=%b st=%0d, want all 0",
                     keycode, keycode_valid, parity_err, frame_err, busy, dbg_state);
        end
        rst_n = 1'b1;
        wait_cyc(10);
        vectors++;
        if (busy !== 1'b0 || dbg_state !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_release: got busy=%b st=%0d, want 0/0", busy, dbg_state);
        end
    endtask

    task automatic test_single();
        frame_expect(8'h1C, 1'b0, 1'b1, -1);
        check_idle("single_1c", 16'h001C);
    endtask

    task automatic test_two_bytes();
        do_reset();
        frame_expect(8'hF0, 1'b1, 1'b1, -1);
        check_idle("two_first", 16'h001C ^ 16'h001C ^ 16'h00F0);
        frame_expect(8'h1C, 1'b0, 1'b1, -1);
        check_idle("two_second", 16'hF01C);
    endtask

    task automatic test_parity_err();
        frame_expect(8'h1C, 1'b1, 1'b1, -1);
        check_idle("parity_bad", 16'hF01C);
        frame_expect(8'h32, 1'b0, 1'b1, -1);
        check_idle("parity_recover", 16'h1C32);
    endtask

    task automatic test_bad_stop();
        frame_expect(8'h45, 1'b0, 1'b0, -1);
        check_idle("bad_stop", 16'h1C32);
    endtask

    task automatic test_glitch();
        @(negedge clk);
        ps2_clk = 1'b0;
        wait_cyc(FILTER_LEN - 2);
        ps2_clk = 1'b1;
        wait_cyc(15);
        vectors++;
        if (busy !== 1'b0 || dbg_state !== 2'd0) begin
            miscompares++;
            $display("FAIL glitch_idle: got busy=%b st=%0d, want 0/0", busy, dbg_state);
        end
        frame_expect(8'h5A, 1'b1, 1'b1, 4);
        check_idle("glitch_frame", 16'h325A);
    endtask

    task automatic test_timeout();
        int n;
        logic [5:0] bits;
        bits = 6'b101100;  // start (bit0=0) followed by five data bits
        exp_q.push_back({K_FRAME, kc_model});
        for (int i = 0; i < 5; i++) ps2_bit(bits[i], 1'b0);
        @(negedge clk);
        ps2_data = bits[5];
        wait_cyc(5);
        ps2_clk = 1'b0;
        // Edge detection costs 2 sync + FILTER_LEN filter + 1 edge cycles, so
        // the pulse lands TIMEOUT_CYC after the detected edge at this count.
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (n == 10) ps2_clk = 1'b1;
            if (n == 50) begin
                vectors++;
                if (busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL timeout_busy: got %b, want 1", busy);
                end
            end
        end while (!frame_err && n < 2 * TIMEOUT_CYC);
        vectors++;
        if (n != FILTER_LEN + TIMEOUT_CYC + 2) begin
            miscompares++;
            $display("FAIL timeout_latency: got %0d cycles, want %0d", n, FILTER_LEN + TIMEOUT_CYC + 2);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_busy_fall: got %b, want 0", busy);
        end
        ps2_data = 1'b1;
        check_idle("timeout", 16'h325A);
        frame_expect(8'h29, 1'b0, 1'b1, -1);
        check_idle("after_timeout", 16'h5A29);
    endtask

    task automatic test_reset_midframe();
        logic [4:0] bits;
        bits = 5'b10110;
        for (int i = 0; i < 5; i++) ps2_bit(bits[i], 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        kc_model = 16'h0000;
        wait_cyc(6);
        vectors++;
        if (keycode !== 16'h0000 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_values: got kc=%h busy=%b, want 0000/0", keycode, busy);
        end
        rst_n = 1'b1;
        wait_cyc(10);
        frame_expect(8'h2B, 1'b1, 1'b1, -1);
        check_idle("midreset", 16'h002B);
    endtask

    task automatic test_back_to_back();
        logic [7:0] b;
        logic       par;
        for (int i = 0; i < 8; i++) begin
            b   = 8'($urandom_range(0, 255));
            par = ~(^b);
            if ($urandom_range(0, 3) == 0) par = ~par;
            frame_expect(b, par, 1'b1, -1);
        end
        check_idle("back_to_back", kc_model);
    endtask

    initial begin
        test_reset();
        test_single();
        test_two_bytes();
        test_parity_err();
        test_bad_stop();
        test_glitch();
        test_timeout();
        test_reset_midframe();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
